// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared defaults and helpers for the ping-pong image buffer.
//               Holds the default lane geometry, the derived word width and
//               the bank-select type used by the top and its bank instances.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int NN_DATA_WIDTH       = 8;
    localparam int NN_LANES            = 6;
    localparam int NN_ADDR_WIDTH       = 7;
    localparam int NN_TOTAL_DATA_WIDTH = NN_DATA_WIDTH * NN_LANES;
    localparam int NN_NUM_BANKS        = 2;

    // One bit is enough to name either bank of the ping-pong pair.
    typedef logic bank_sel_t;

    // Word width for a given lane width and lane count.
    function automatic int nn_total_width(input int data_width, input int lanes);
        return data_width * lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_img_bank.sv
`default_nettype none
// ============================================================================
// Module      : nn_img_bank
// Description : One buffer bank: 2**ADDR_WIDTH words, single write port with
//               per-lane write mask, single synchronous read port. Contents
//               are never reset so the array maps onto block RAM.
// Ports       : i_clk       clock
//               i_wr_en     write strobe (already qualified by the top)
//               i_wr_addr   write word address
//               i_wr_data   write word, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//               i_wr_mask   per-lane write enable
//               i_rd_en     read strobe (already qualified by the top)
//               i_rd_addr   read word address
//               o_rd_data   registered read word, holds between reads
// Revision    : 1.0 - initial release
// ============================================================================
module nn_img_bank
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int LANES      = NN_LANES,
    parameter int ADDR_WIDTH = NN_ADDR_WIDTH
) (
    input  logic                                      i_clk,
    input  logic                                      i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                     i_wr_addr,
    input  logic [nn_total_width(DATA_WIDTH, LANES)-1:0] i_wr_data,
    input  logic [LANES-1:0]                          i_wr_mask,
    input  logic                                      i_rd_en,
    input  logic [ADDR_WIDTH-1:0]                     i_rd_addr,
    output logic [nn_total_width(DATA_WIDTH, LANES)-1:0] o_rd_data
);

    localparam int TOTAL_DATA_WIDTH = nn_total_width(DATA_WIDTH, LANES);
    localparam int DEPTH            = 1 << ADDR_WIDTH;

    logic [TOTAL_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [TOTAL_DATA_WIDTH-1:0] rd_data_q;

    // Lane-masked write: unmasked lanes keep their previous contents.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_wr_mask[k]) begin
                    mem_q[i_wr_addr][k*DATA_WIDTH +: DATA_WIDTH] <=
                        i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read register only loads on a read so the last word is held.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/nn_img_pp_bf.sv
`default_nettype none
// ============================================================================
// Module      : nn_img_pp_bf
// Description : Two-bank ping-pong image buffer. The producer fills the
//               current write bank and hands it over with i_wr_done; the
//               consumer reads the current read bank and releases it with
//               i_rd_done. Requests against a bank that is not available are
//               dropped and raise the sticky o_err flag.
// Ports       : i_clk, i_rst (async, active-high)
//               i_wr_en/i_wr_addr/i_wr_data/i_wr_mask  masked word write
//               i_wr_done                               hand write bank over
//               i_rd_en/i_rd_addr                       word read request
//               i_rd_done                               release read bank
//               o_rd_data/o_rd_valid                    read result, latency 1
//               o_wr_ready/o_rd_ready                   bank availability
//               o_err                                   sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module nn_img_pp_bf
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int LANES      = NN_LANES,
    parameter int ADDR_WIDTH = NN_ADDR_WIDTH
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                     i_wr_addr,
    input  logic [nn_total_width(DATA_WIDTH, LANES)-1:0] i_wr_data,
    input  logic [LANES-1:0]                          i_wr_mask,
    input  logic                                      i_wr_done,
    input  logic                                      i_rd_en,
    input  logic [ADDR_WIDTH-1:0]                     i_rd_addr,
    input  logic                                      i_rd_done,
    output logic [nn_total_width(DATA_WIDTH, LANES)-1:0] o_rd_data,
    output logic                                      o_rd_valid,
    output logic                                      o_wr_ready,
    output logic                                      o_rd_ready,
    output logic                                      o_err
);

    localparam int TOTAL_DATA_WIDTH = nn_total_width(DATA_WIDTH, LANES);

    bank_sel_t               wr_sel_q, wr_sel_d;
    bank_sel_t               rd_sel_q, rd_sel_d;
    logic [NN_NUM_BANKS-1:0] full_q,   full_d;
    logic                    err_q,    err_d;
    logic                    rd_valid_q;
    bank_sel_t               rd_bank_q;
    logic                    rd_live_q;

    logic                        w_wr_ready;
    logic                        w_rd_ready;
    logic                        w_wr_acc;
    logic                        w_wr_done_acc;
    logic                        w_rd_acc;
    logic                        w_rd_done_acc;
    logic                        w_violation;
    logic [TOTAL_DATA_WIDTH-1:0] w_bank_rd_data [NN_NUM_BANKS];

    // ------------------------------------------------------------------
    // Availability and request qualification
    // ------------------------------------------------------------------
    assign w_wr_ready    = ~full_q[wr_sel_q];
    assign w_rd_ready    =  full_q[rd_sel_q];

    assign w_wr_acc      = i_wr_en   & w_wr_ready;
    assign w_wr_done_acc = i_wr_done & w_wr_ready;
    assign w_rd_acc      = i_rd_en   & w_rd_ready;
    assign w_rd_done_acc = i_rd_done & w_rd_ready;

    assign w_violation   = ((i_wr_en | i_wr_done) & ~w_wr_ready) |
                           ((i_rd_en | i_rd_done) & ~w_rd_ready);

    // A write bank is empty and a read bank is full, so when both handovers
    // are accepted in one cycle they always touch different full bits.
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        err_d    = err_q | w_violation;
        if (w_wr_done_acc) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (w_rd_done_acc) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            full_q     <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_live_q  <= 1'b0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            full_q     <= full_d;
            err_q      <= err_d;
            rd_valid_q <= w_rd_acc;
            if (w_rd_acc) begin
                rd_bank_q <= rd_sel_q;
                rd_live_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank instances. Strobes are masked by reset so an edge seen while
    // reset is held never disturbs memory or the bank read registers.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NN_NUM_BANKS; b++) begin : g_bank
        logic w_bank_wr_en;
        logic w_bank_rd_en;

        assign w_bank_wr_en = w_wr_acc & (wr_sel_q == bank_sel_t'(b)) & ~i_rst;
        assign w_bank_rd_en = w_rd_acc & (rd_sel_q == bank_sel_t'(b)) & ~i_rst;

        nn_img_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .LANES      (LANES),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .i_clk      (i_clk),
            .i_wr_en    (w_bank_wr_en),
            .i_wr_addr  (i_wr_addr),
            .i_wr_data  (i_wr_data),
            .i_wr_mask  (i_wr_mask),
            .i_rd_en    (w_bank_rd_en),
            .i_rd_addr  (i_rd_addr),
            .o_rd_data  (w_bank_rd_data[b])
        );
    end

    // ------------------------------------------------------------------
    // Outputs. The read word lives in the bank's read register; the top
    // remembers which bank was read last and forces zero until the first
    // read after reset, which gives an immediately-cleared registered
    // output without resetting the RAM-side register.
    // ------------------------------------------------------------------
    assign o_rd_data  = rd_live_q ? w_bank_rd_data[rd_bank_q] : '0;
    assign o_rd_valid = rd_valid_q;
    assign o_wr_ready = w_wr_ready;
    assign o_rd_ready = w_rd_ready;
    assign o_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_img_pp_bf.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_img_pp_bf
// Description : Self-checking bench for nn_img_pp_bf with directed scenarios
//               and a randomized run against a behavioural buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_img_pp_bf;

    localparam int DW = 8;
    localparam int L  = 6;
    localparam int AW = 7;
    localparam int TW = DW * L;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [TW-1:0] wr_data = '0;
    logic [L-1:0]  wr_mask = '0;
    logic          wr_done = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_done = 1'b0;
    logic [TW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_ready;
    logic          rd_ready;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: two banks as plain arrays, with a per-lane "known"
    // mask so lanes never written since reset are not compared.
    logic [TW-1:0] m_mem   [2][1<<AW];
    logic [L-1:0]  m_kn    [2][1<<AW];
    logic [1:0]    m_full;
    int            m_wsel, m_rsel;
    logic          m_err, m_valid;
    logic [TW-1:0] m_data;
    logic [L-1:0]  m_known;

    always #5 clk = ~clk;

    nn_img_pp_bf #(.DATA_WIDTH(DW), .LANES(L), .ADDR_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_wr_mask  (wr_mask),
        .i_wr_done  (wr_done),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .i_rd_done  (rd_done),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_wr_ready (wr_ready),
        .o_rd_ready (rd_ready),
        .o_err      (err)
    );

    function automatic logic [TW-1:0] lane_bits(input logic [L-1:0] m);
        logic [TW-1:0] r = '0;
        for (int k = 0; k < L; k++) if (m[k]) r[k*DW +: DW] = '1;
        return r;
    endfunction

    task automatic model_reset();
        m_full = 2'b00; m_wsel = 0; m_rsel = 0;
        m_err = 1'b0; m_valid = 1'b0; m_data = '0; m_known = '1;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < (1<<AW); a++) m_kn[b][a] = '0;
    endtask

    // Drive one cycle of requests, advance the model, land at edge + 1.
    task automatic tick(input logic we, input logic [AW-1:0] wa, input logic [TW-1:0] wd,
                        input logic [L-1:0] wm, input logic wdn,
                        input logic re, input logic [AW-1:0] ra, input logic rdn);
        bit wr_ok, rd_ok;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm; wr_done = wdn;
        rd_en = re; rd_addr = ra; rd_done = rdn;
        wr_ok   = !m_full[m_wsel];
        rd_ok   =  m_full[m_rsel];
        m_valid = 1'b0;
        if (re) begin
            if (rd_ok) begin
                m_data = m_mem[m_rsel][ra]; m_known = m_kn[m_rsel][ra]; m_valid = 1'b1;
            end else m_err = 1'b1;
        end
        if (we) begin
            if (wr_ok) begin
                for (int k = 0; k < L; k++) if (wm[k]) begin
                    m_mem[m_wsel][wa][k*DW +: DW] = wd[k*DW +: DW];
                    m_kn[m_wsel][wa][k] = 1'b1;
                end
            end else m_err = 1'b1;
        end
        if (rdn) begin
            if (rd_ok) begin m_full[m_rsel] = 1'b0; m_rsel = 1 - m_rsel; end
            else m_err = 1'b1;
        end
        if (wdn) begin
            if (wr_ok) begin m_full[m_wsel] = 1'b1; m_wsel = 1 - m_wsel; end
            else m_err = 1'b1;
        end
        @(posedge clk); #1;
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0; wr_mask = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [TW-1:0] d, input logic [L-1:0] m);
        tick(1, a, d, m, 0, 0, '0, 0);
    endtask
    task automatic wdone();  tick(0, '0, '0, '0, 1, 0, '0, 0); endtask
    task automatic rd(input logic [AW-1:0] a); tick(0, '0, '0, '0, 0, 1, a, 0); endtask
    task automatic rdone();  tick(0, '0, '0, '0, 0, 0, '0, 1); endtask
    task automatic idle();   tick(0, '0, '0, '0, 0, 0, '0, 0); endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", rd_data); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_ready got wr=%b rd=%b want wr=1 rd=0", wr_ready, rd_ready); end
        do_reset();
        n_checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin n_fail++;
            $display("FAIL release_ready got wr=%b rd=%b want wr=1 rd=0", wr_ready, rd_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        wr(7'd3, 48'h0605_0403_0201, 6'h3F);
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_before got %b want 0", rd_ready); end
        wdone();
        n_checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b1) begin n_fail++;
            $display("FAIL basic_swap got wr=%b rd=%b want 1 1", wr_ready, rd_ready); end
        rd(7'd3);
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 48'h0605_0403_0201) begin n_fail++;
            $display("FAIL basic_read got v=%b d=%h want v=1 d=060504030201", rd_valid, rd_data); end
        idle();
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 48'h0605_0403_0201) begin n_fail++;
            $display("FAIL basic_hold got v=%b d=%h want v=0 d=060504030201", rd_valid, rd_data); end
        rdone();
        n_checks++; if (rd_ready !== 1'b0 || err !== 1'b0) begin n_fail++;
            $display("FAIL basic_release got rd=%b err=%b want 0 0", rd_ready, err); end
    endtask

    // Runs straight after test_basic: bank0 holds 0x060504030201 at addr 3.
    task automatic test_mask_overwrite();
        wr(7'd3, 48'h1111_1111_1111, 6'h3F);            // bank1
        wdone();
        wr(7'd3, 48'hFFFF_FFFF_FFFF, 6'b000101);        // bank0, lanes 0 and 2
        wdone();
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL mask_both_full got %b want 0", wr_ready); end
        tick(0, '0, '0, '0, 0, 1, 7'd3, 1);             // read + release together
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 48'h1111_1111_1111) begin n_fail++;
            $display("FAIL mask_old_bank got v=%b d=%h want v=1 d=111111111111", rd_valid, rd_data); end
        rd(7'd3);
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 48'h0605_04FF_02FF) begin n_fail++;
            $display("FAIL mask_merge got v=%b d=%h want v=1 d=060504ff02ff", rd_valid, rd_data); end
        rdone();
    endtask

    task automatic test_overflow();
        do_reset();
        wr(7'd5, 48'hAAAA_0000_AAAA, 6'h3F); wdone();
        wr(7'd5, 48'hBBBB_0000_BBBB, 6'h3F); wdone();
        n_checks++; if (wr_ready !== 1'b0 || err !== 1'b0) begin n_fail++;
            $display("FAIL ovf_full got wr=%b err=%b want 0 0", wr_ready, err); end
        wr(7'd5, 48'hCCCC_CCCC_CCCC, 6'h3F);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b want 1", err); end
        wdone();                                         // also ignored
        rd(7'd5);
        n_checks++; if (rd_data !== 48'hAAAA_0000_AAAA) begin n_fail++;
            $display("FAIL ovf_bank0 got %h want aaaa0000aaaa", rd_data); end
        rdone();
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_release got %b want 1", wr_ready); end
        rd(7'd5);
        n_checks++; if (rd_data !== 48'hBBBB_0000_BBBB) begin n_fail++;
            $display("FAIL ovf_bank1 got %h want bbbb0000bbbb", rd_data); end
        rdone();
        n_checks++; if (rd_ready !== 1'b0 || err !== 1'b1) begin n_fail++;
            $display("FAIL ovf_end got rd=%b err=%b want 0 1", rd_ready, err); end
    endtask

    task automatic test_simul_swap();
        do_reset();
        wr(7'd9, 48'hD0D0_D0D0_D0D0, 6'h3F); wdone();
        wr(7'd9, 48'hD1D1_D1D1_D1D1, 6'h3F);
        tick(0, '0, '0, '0, 1, 0, '0, 1);
        n_checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b1 || err !== 1'b0) begin n_fail++;
            $display("FAIL swap_flags got wr=%b rd=%b err=%b want 1 1 0", wr_ready, rd_ready, err); end
        rd(7'd9);
        n_checks++; if (rd_data !== 48'hD1D1_D1D1_D1D1) begin n_fail++;
            $display("FAIL swap_rdsel got %h want d1d1d1d1d1d1", rd_data); end
        wr(7'd10, 48'hEEEE_EEEE_EEEE, 6'h3F); wdone();  // lands in bank0
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL swap_wrsel got %b want 0", wr_ready); end
    endtask

    task automatic test_empty_read();
        do_reset();
        rd(7'd0);
        n_checks++; if (rd_valid !== 1'b0 || err !== 1'b1 || rd_data !== '0) begin n_fail++;
            $display("FAIL empty_read got v=%b err=%b d=%h want 0 1 0", rd_valid, err, rd_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        rd(7'd1);                                       // sets err
        wr(7'd2, 48'hA5A5_A5A5_A5A5, 6'h3F); wdone();
        rd(7'd2);
        n_checks++; if (rd_valid !== 1'b1 || err !== 1'b1 || rd_data !== 48'hA5A5_A5A5_A5A5) begin n_fail++;
            $display("FAIL areset_pre got v=%b err=%b d=%h", rd_valid, err, rd_data); end
        wr(7'd4, 48'h1234_5678_9ABC, 6'h3F);           // mid-fill of bank1
        #2 rst = 1'b1;
        #1;
        n_checks++; if (rd_valid !== 1'b0 || err !== 1'b0 || rd_data !== '0) begin n_fail++;
            $display("FAIL areset_out got v=%b err=%b d=%h want 0 0 0", rd_valid, err, rd_data); end
        n_checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin n_fail++;
            $display("FAIL areset_ready got wr=%b rd=%b want 1 0", wr_ready, rd_ready); end
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0 || err !== 1'b0) begin n_fail++;
            $display("FAIL areset_after got wr=%b rd=%b err=%b want 1 0 0", wr_ready, rd_ready, err); end
    endtask

    task automatic test_random();
        logic [63:0] d64;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c % 200 == 199) do_reset();
            d64 = {$urandom, $urandom};
            tick(($urandom % 3) != 0, AW'($urandom % 8), d64[TW-1:0], L'($urandom),
                 ($urandom % 7) == 0, ($urandom % 2) == 0, AW'($urandom % 8),
                 ($urandom % 7) == 0);
            n_checks++; if (wr_ready !== !m_full[m_wsel] || rd_ready !== m_full[m_rsel]) begin n_fail++;
                $display("FAIL rnd_ready c=%0d got wr=%b rd=%b want wr=%b rd=%b",
                         c, wr_ready, rd_ready, !m_full[m_wsel], m_full[m_rsel]); end
            n_checks++; if (rd_valid !== m_valid) begin n_fail++;
                $display("FAIL rnd_valid c=%0d got %b want %b", c, rd_valid, m_valid); end
            n_checks++; if (err !== m_err) begin n_fail++;
                $display("FAIL rnd_err c=%0d got %b want %b", c, err, m_err); end
            n_checks++; if (((rd_data ^ m_data) & lane_bits(m_known)) !== '0) begin n_fail++;
                $display("FAIL rnd_data c=%0d got %h want %h known %b", c, rd_data, m_data, m_known); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_mask_overwrite();
        test_overflow();
        test_simul_swap();
        test_empty_read();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
